// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-side memory responder: access size codes,
// FSM state encoding, debug view of the FSM, and the alignment check.
package dmem_responder_pkg;

    // Access size codes as presented on SIZE
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } dmem_state_t;

    // Observable internals so checkers can follow the FSM without probing
    // hierarchy: current state, wait counter and the DDT output enable.
    typedef struct packed {
        dmem_state_t state;
        logic [3:0]  cnt;
        logic        ddt_oe;
    } dmem_dbg_t;

    // True when the access cannot be served: a half on an odd byte, a word
    // on any nonzero offset, or the reserved size code.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_WORD: bad = (offset != 2'b00);
            SIZE_HALF: bad = offset[0];
            SIZE_BYTE: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// Big-endian byte-lane steering for the data responder. Produces the word to
// write back (old word with the addressed lanes replaced) and the
// right-justified, zero-extended read value for the addressed lanes.
module dmem_lane_steer
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic [31:0] old_word,
    input  logic [31:0] store_data,
    output logic [31:0] wr_word,
    output logic [31:0] rd_val
);

    // Big-endian: byte offset 0 lives in bits [31:24], so the lane number
    // counted from the LSB is the inverted offset.
    logic [1:0] byte_lane;
    logic       half_lane;

    assign byte_lane = ~offset;
    assign half_lane = ~offset[1];

    // Merge store lanes into the old word and extract the read lanes
    always_comb begin
        wr_word = old_word;
        rd_val  = 32'h0;
        case (size)
            SIZE_WORD: begin
                wr_word = store_data;
                rd_val  = old_word;
            end
            SIZE_HALF: begin
                wr_word[{half_lane, 4'b0000} +: 16] = store_data[15:0];
                rd_val = {16'h0, old_word[{half_lane, 4'b0000} +: 16]};
            end
            SIZE_BYTE: begin
                wr_word[{byte_lane, 3'b000} +: 8] = store_data[7:0];
                rd_val = {24'h0, old_word[{byte_lane, 3'b000} +: 8]};
            end
            default: begin
                wr_word = old_word;
                rd_val  = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: target end of the CPU data bus. Accepts one
// request at a time, inserts WAIT wait states, then completes with a single
// active-low ACKD_n cycle, driving load data or committing store data.
//
// Handshake: the CPU raises MREQ with DAD/WRITE/SIZE (and store data on DDT)
// valid; the request is taken on the first rising edge in IDLE that sees
// MREQ=1. The CPU must keep MREQ high until it sees ACKD_n=0; dropping MREQ
// while waiting abandons the request without an acknowledge. ACKD_n is low
// for exactly one cycle, and MREQ is ignored on the edge that ends it, so a
// new request is taken no earlier than the following edge.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] DAD,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    inout  wire  [31:0] DDT,
    output logic        ACKD_n,
    output logic        BERR,
    output dmem_dbg_t   dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // FSM and wait counter
    dmem_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;

    // Request registers captured at acceptance
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [1:0]            req_off;
    logic [1:0]            req_size;
    logic                  req_write;
    logic [31:0]           req_wdata;
    logic                  req_err;

    // Word array and its registered read port
    logic [31:0]           mem [DEPTH];
    logic [31:0]           rdata;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  enter_ack;
    logic                  commit;

    // Lane-steered values
    logic [31:0] wr_word;
    logic [31:0] rd_val;

    // Bus drive
    logic        ddt_oe;
    logic [31:0] ddt_val;

    // Address bits above the array index are ignored: the array aliases.
    logic dad_unused;
    assign dad_unused = ^DAD[31:DEPTH_LOG2+2];

    // State and counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT (abort if MREQ
    // drops), and spend exactly one cycle in ACK without sampling MREQ.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MREQ) begin
                    accept = 1'b1;
                    if (WAIT == 0) begin
                        state_next = ST_ACK;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = 4'(WAIT - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!MREQ) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_next = ST_ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Capture the request (including store data from DDT) on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_idx   <= '0;
            req_off   <= 2'b00;
            req_size  <= SIZE_WORD;
            req_write <= 1'b0;
            req_wdata <= 32'h0;
        end else if (accept) begin
            req_idx   <= DAD[DEPTH_LOG2+1:2];
            req_off   <= DAD[1:0];
            req_size  <= SIZE;
            req_write <= WRITE;
            req_wdata <= DDT;
        end
    end

    assign req_err = is_misaligned(req_size, req_off);

    // With WAIT=0 the read happens on the accepting edge, before req_idx is
    // loaded, so the index comes straight from the bus in that case.
    assign rd_idx    = (state == ST_IDLE) ? DAD[DEPTH_LOG2+1:2] : req_idx;
    assign enter_ack = !rst && (state_next == ST_ACK) && (state != ST_ACK);
    assign commit    = !rst && (state == ST_ACK) && req_write && !req_err;

    // Array read into rdata on entry to ACK; write commit on the edge leaving
    // ACK. The array itself is never cleared by reset.
    always_ff @(posedge clk) begin
        if (enter_ack) begin
            rdata <= mem[rd_idx];
        end
        if (commit) begin
            mem[req_idx] <= wr_word;
        end
    end

    dmem_lane_steer u_lane_steer (
        .offset     (req_off),
        .size       (req_size),
        .old_word   (rdata),
        .store_data (req_wdata),
        .wr_word    (wr_word),
        .rd_val     (rd_val)
    );

    // DDT is only ever driven in ACK of a load, so a CPU store never contends.
    assign ddt_oe  = (state == ST_ACK) && !req_write;
    assign ddt_val = req_err ? 32'h0 : rd_val;
    assign DDT     = ddt_oe ? ddt_val : 'z;

    assign ACKD_n = (state != ST_ACK);
    assign BERR   = (state == ST_ACK) && req_err;

    assign dbg.state  = state;
    assign dbg.cnt    = cnt;
    assign dbg.ddt_oe = ddt_oe;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT=2, WAIT=0, WAIT=3) share a
// clock and reset. Drivers push the expected acknowledge into exp_q; a monitor
// on the falling edge pops and compares whenever an ACKD_n is seen low.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    // Expected item: {inst[1:0], berr, is_read, data[31:0], ack_cycle[31:0]}
    localparam int EW = 68;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    int   cyc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT signals ----------------
    logic [2:0]  mreq;
    logic [2:0]  wr;
    logic [2:0]  cpu_oe;
    logic [1:0]  sz     [3];
    logic [31:0] dad    [3];
    logic [31:0] cpu_wd [3];
    logic [2:0]  ackd_n;
    logic [2:0]  berr;
    wire  [31:0] ddt0, ddt1, ddt2;
    dmem_dbg_t   dbg0, dbg1, dbg2;

    assign ddt0 = cpu_oe[0] ? cpu_wd[0] : 'z;
    assign ddt1 = cpu_oe[1] ? cpu_wd[1] : 'z;
    assign ddt2 = cpu_oe[2] ? cpu_wd[2] : 'z;

    dmem_responder #(.DEPTH_LOG2(10), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst), .DAD(dad[0]), .MREQ(mreq[0]), .WRITE(wr[0]),
        .SIZE(sz[0]), .DDT(ddt0), .ACKD_n(ackd_n[0]), .BERR(berr[0]), .dbg(dbg0)
    );
    dmem_responder #(.DEPTH_LOG2(10), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .DAD(dad[1]), .MREQ(mreq[1]), .WRITE(wr[1]),
        .SIZE(sz[1]), .DDT(ddt1), .ACKD_n(ackd_n[1]), .BERR(berr[1]), .dbg(dbg1)
    );
    dmem_responder #(.DEPTH_LOG2(10), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .DAD(dad[2]), .MREQ(mreq[2]), .WRITE(wr[2]),
        .SIZE(sz[2]), .DDT(ddt2), .ACKD_n(ackd_n[2]), .BERR(berr[2]), .dbg(dbg2)
    );

    function automatic int wait_of(input int i);
        case (i)
            0:       return 2;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic dmem_dbg_t dbg_of(input int i);
        case (i)
            0:       return dbg0;
            1:       return dbg1;
            default: return dbg2;
        endcase
    endfunction

    function automatic logic [31:0] ddt_of(input int i);
        case (i)
            0:       return ddt0;
            1:       return ddt1;
            default: return ddt2;
        endcase
    endfunction

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int checks;
    int failures;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic void push_exp(input int inst, input logic eb,
                                     input logic is_rd, input logic [31:0] data,
                                     input int ack_cyc);
        exp_q.push_back({2'(inst), eb, is_rd, data, 32'(ack_cyc)});
    endfunction

    // Monitor: every falling edge, each instance either acknowledges (pop and
    // compare) or must be quiet (no BERR, DDT released).
    always @(negedge clk) begin
        logic [EW-1:0] e;
        dmem_dbg_t     d;
        for (int i = 0; i < 3; i++) begin
            d = dbg_of(i);
            if (ackd_n[i] == 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack inst=%0d cycle=%0d actual=ack required=none", i, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_inst", 32'(i), 32'(e[67:66]));
                    check("ack_cycle", 32'(cyc), e[31:0]);
                    check("ack_berr", 32'(berr[i]), 32'(e[65]));
                    check("ack_ddt_oe", 32'(d.ddt_oe), 32'(e[64]));
                    if (e[64]) check("ack_rdata", ddt_of(i), e[63:32]);
                end
            end else begin
                check("quiet_berr", 32'(berr[i]), 32'h0);
                check("quiet_ddt_oe", 32'(d.ddt_oe), 32'h0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Wait for n acknowledges from one instance, then release the bus.
    task automatic wait_ack(input int inst, input int n);
        int seen;
        int budget;
        seen   = 0;
        budget = 0;
        while (seen < n && budget < 64) begin
            @(negedge clk);
            budget++;
            if (ackd_n[inst] == 1'b0) seen++;
        end
        if (seen < n) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout inst=%0d actual=%0d required=%0d", inst, seen, n);
        end
        mreq[inst]   = 1'b0;
        cpu_oe[inst] = 1'b0;
    endtask

    task automatic access(input int inst, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic eb, input logic [31:0] ed);
        @(negedge clk);
        mreq[inst]   = 1'b1;
        wr[inst]     = w;
        sz[inst]     = s;
        dad[inst]    = a;
        cpu_wd[inst] = wd;
        cpu_oe[inst] = w;
        push_exp(inst, eb, !w, ed, cyc + 1 + wait_of(inst));
        wait_ack(inst, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        dmem_dbg_t d;
        int        c0;
        int        budget;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        mreq     = '0;
        wr       = '0;
        cpu_oe   = '0;
        for (int i = 0; i < 3; i++) begin
            sz[i]     = SIZE_WORD;
            dad[i]    = 32'h0;
            cpu_wd[i] = 32'h0;
        end

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            d = dbg_of(i);
            check("rst_ackd_n", 32'(ackd_n[i]), 32'h1);
            check("rst_berr", 32'(berr[i]), 32'h0);
            check("rst_state", 32'(d.state), 32'(ST_IDLE));
            check("rst_cnt", 32'(d.cnt), 32'h0);
            check("rst_ddt_oe", 32'(d.ddt_oe), 32'h0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // WAIT=2: word store/load, aliasing above the index bits
        access(0, 1'b1, SIZE_WORD, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0);
        access(0, 1'b0, SIZE_WORD, 32'h0000_0100, 32'h0,         1'b0, 32'hDEAD_BEEF);
        access(0, 1'b0, SIZE_WORD, 32'h0000_1100, 32'h0,         1'b0, 32'hDEAD_BEEF);

        // Byte stores (upper lanes of DDT carry junk), then lane reads
        access(0, 1'b1, SIZE_BYTE, 32'h0000_0200, 32'hA5A5_A511, 1'b0, 32'h0);
        access(0, 1'b1, SIZE_BYTE, 32'h0000_0201, 32'hA5A5_A522, 1'b0, 32'h0);
        access(0, 1'b1, SIZE_BYTE, 32'h0000_0202, 32'hA5A5_A533, 1'b0, 32'h0);
        access(0, 1'b1, SIZE_BYTE, 32'h0000_0203, 32'hA5A5_A544, 1'b0, 32'h0);
        access(0, 1'b0, SIZE_WORD, 32'h0000_0200, 32'h0, 1'b0, 32'h1122_3344);
        access(0, 1'b0, SIZE_HALF, 32'h0000_0202, 32'h0, 1'b0, 32'h0000_3344);
        access(0, 1'b0, SIZE_HALF, 32'h0000_0200, 32'h0, 1'b0, 32'h0000_1122);
        access(0, 1'b0, SIZE_BYTE, 32'h0000_0201, 32'h0, 1'b0, 32'h0000_0022);
        access(0, 1'b0, SIZE_BYTE, 32'h0000_0203, 32'h0, 1'b0, 32'h0000_0044);

        // Error cases around word 0x300
        access(0, 1'b1, SIZE_WORD, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 32'h0);
        access(0, 1'b1, SIZE_HALF, 32'h0000_0301, 32'h0000_BEEF, 1'b1, 32'h0);
        access(0, 1'b0, SIZE_WORD, 32'h0000_0300, 32'h0, 1'b0, 32'hCAFE_F00D);
        access(0, 1'b0, SIZE_RSVD, 32'h0000_0300, 32'h0, 1'b1, 32'h0);
        access(0, 1'b0, SIZE_WORD, 32'h0000_0302, 32'h0, 1'b1, 32'h0);
        access(0, 1'b1, SIZE_HALF, 32'h0000_0302, 32'h5555_1234, 1'b0, 32'h0);
        access(0, 1'b0, SIZE_WORD, 32'h0000_0300, 32'h0, 1'b0, 32'hCAFE_1234);

        // WAIT=0 with MREQ held high: ACKs on alternate cycles
        access(1, 1'b1, SIZE_WORD, 32'h0000_0040, 32'h0BAD_F00D, 1'b0, 32'h0);
        @(negedge clk);
        mreq[1] = 1'b1;
        wr[1]   = 1'b0;
        sz[1]   = SIZE_WORD;
        dad[1]  = 32'h0000_0040;
        c0      = cyc;
        push_exp(1, 1'b0, 1'b1, 32'h0BAD_F00D, c0 + 1);
        push_exp(1, 1'b0, 1'b1, 32'h0BAD_F00D, c0 + 3);
        push_exp(1, 1'b0, 1'b1, 32'h0BAD_F00D, c0 + 5);
        wait_ack(1, 3);

        // WAIT=3: store abandoned by dropping MREQ while waiting
        access(2, 1'b1, SIZE_WORD, 32'h0000_0080, 32'h1234_5678, 1'b0, 32'h0);
        @(negedge clk);
        mreq[2]   = 1'b1;
        wr[2]     = 1'b1;
        sz[2]     = SIZE_WORD;
        dad[2]    = 32'h0000_0080;
        cpu_wd[2] = 32'hAAAA_AAAA;
        cpu_oe[2] = 1'b1;
        repeat (2) @(negedge clk);
        mreq[2]   = 1'b0;
        cpu_oe[2] = 1'b0;
        repeat (6) @(negedge clk);
        d = dbg_of(2);
        check("abort_state", 32'(d.state), 32'(ST_IDLE));
        check("abort_cnt", 32'(d.cnt), 32'h0);
        access(2, 1'b0, SIZE_WORD, 32'h0000_0080, 32'h0, 1'b0, 32'h1234_5678);

        // Reset pulsed during ACK of a read
        @(negedge clk);
        mreq[2] = 1'b1;
        wr[2]   = 1'b0;
        sz[2]   = SIZE_WORD;
        dad[2]  = 32'h0000_0080;
        push_exp(2, 1'b0, 1'b1, 32'h1234_5678, cyc + 4);
        budget = 0;
        while (ackd_n[2] != 1'b0 && budget < 64) begin
            @(negedge clk);
            budget++;
        end
        check("rst_mid_ack_seen", 32'(ackd_n[2]), 32'h0);
        mreq[2] = 1'b0;
        #2 rst = 1'b1;
        #1;
        d = dbg_of(2);
        check("rst_mid_ackd_n", 32'(ackd_n[2]), 32'h1);
        check("rst_mid_ddt_oe", 32'(d.ddt_oe), 32'h0);
        check("rst_mid_state", 32'(d.state), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        access(2, 1'b0, SIZE_WORD, 32'h0000_0080, 32'h0, 1'b0, 32'h1234_5678);
        access(0, 1'b0, SIZE_WORD, 32'h0000_0200, 32'h0, 1'b0, 32'h1122_3344);

        repeat (4) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
